// File: rtl/banner_pkg.sv
// Shared definitions for the banner blitter and the frame-buffer address helper.
package banner_pkg;

    // Frame-buffer geometry (640x480, one 8-bit colour index per word)
    localparam int FB_WIDTH  = 640;
    localparam int FB_HEIGHT = 480;
    localparam int FB_AW     = 19;
    localparam int COLOR_W   = 8;

    // Screen-coordinate sums carry one extra bit so off-screen values clip
    // instead of wrapping back onto the display.
    localparam int SX_W = 11;
    localparam int SY_W = 10;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        WRITE,
        DONE
    } blit_state_t;

endpackage

// File: rtl/text_banner_blitter_if.sv
// Frame-buffer write port: the blitter requests, the arbiter acknowledges.
interface text_banner_blitter_if;
    import banner_pkg::*;

    logic               fb_we;
    logic [FB_AW-1:0]   fb_addr;
    logic [COLOR_W-1:0] fb_data;
    logic               fb_ack;

    modport master (
        output fb_we,
        output fb_addr,
        output fb_data,
        input  fb_ack
    );

    modport slave (
        input  fb_we,
        input  fb_addr,
        input  fb_data,
        output fb_ack
    );

endinterface

// File: rtl/fb_addr_calc.sv
// Screen (X,Y) to frame-buffer word address, plus an off-screen flag.
// Purely combinational; also used by the sprite blitters.
module fb_addr_calc
    import banner_pkg::*;
(
    input  logic [SX_W-1:0]  scr_x,
    input  logic [SY_W-1:0]  scr_y,
    output logic [FB_AW-1:0] fb_addr,
    output logic             clip
);

    logic [FB_AW-1:0] x_ext;
    logic [FB_AW-1:0] y_ext;

    assign x_ext = FB_AW'(scr_x[9:0]);
    assign y_ext = FB_AW'(scr_y[8:0]);

    // Y*640 as Y*512 + Y*128: two shifts and an add, no multiplier.
    assign fb_addr = (y_ext << 9) + (y_ext << 7) + x_ext;

    // The wide sums keep the carry bit, so anything past the right or
    // bottom edge is caught here rather than aliasing onto the screen.
    assign clip = (scr_x >= SX_W'(FB_WIDTH)) || (scr_y >= SY_W'(FB_HEIGHT));

endmodule

// File: rtl/text_banner_blitter.sv
// Walks a TEXT_W x TEXT_H text bitmap in row-major order and writes one
// colour index per pixel into the frame buffer at a latched screen origin.
module text_banner_blitter
    import banner_pkg::*;
#(
    parameter int TEXT_W      = 24,
    parameter int TEXT_H      = 32,
    parameter bit TRANSPARENT = 1'b0
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               start,
    input  logic [9:0]         origin_x,
    input  logic [8:0]         origin_y,
    input  logic [COLOR_W-1:0] fg_color,
    input  logic [COLOR_W-1:0] bg_color,
    output logic [5:0]         map_x,
    output logic [4:0]         map_y,
    input  logic               map_pixel,
    text_banner_blitter_if.master fb,
    output logic               busy,
    output logic               done
);

    localparam logic [5:0] CX_LAST = 6'(TEXT_W - 1);
    localparam logic [4:0] CY_LAST = 5'(TEXT_H - 1);

    blit_state_t        state;
    blit_state_t        state_nxt;

    logic [9:0]         org_x;
    logic [8:0]         org_y;
    logic [COLOR_W-1:0] fg_q;
    logic [COLOR_W-1:0] bg_q;
    logic [5:0]         cx;
    logic [4:0]         cy;
    logic [FB_AW-1:0]   addr_q;
    logic [COLOR_W-1:0] data_q;

    logic [SX_W-1:0]    scr_x;
    logic [SY_W-1:0]    scr_y;
    logic [FB_AW-1:0]   pix_addr;
    logic               pix_clip;
    logic               last_pix;
    logic               skip;
    logic               accept;
    logic               wr_done;
    logic               advance;

    assign scr_x = {1'b0, org_x} + SX_W'(cx);
    assign scr_y = {1'b0, org_y} + SY_W'(cy);

    fb_addr_calc u_addr_calc (
        .scr_x   (scr_x),
        .scr_y   (scr_y),
        .fb_addr (pix_addr),
        .clip    (pix_clip)
    );

    assign last_pix = (cx == CX_LAST) && (cy == CY_LAST);
    assign skip     = pix_clip || (TRANSPARENT && !map_pixel);
    assign accept   = (state == IDLE) && start;
    assign wr_done  = (state == WRITE) && fb.fb_ack;
    // The counters freeze on the last pixel so map_x/map_y hold their final
    // value until the next render.
    assign advance  = ((state == FETCH) && skip || wr_done) && !last_pix;

    // State register; Reset drops any render in flight without a done pulse.
    always_ff @(posedge Clk) begin
        // NOTE: non-blocking assignments in clocked blocks, so every register
        // samples the pre-edge value of every other register.
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state decode.
    always_comb begin
        // NOTE: default first so every path assigns state_nxt and no latch
        // is inferred.
        state_nxt = state;
        unique case (state)
            IDLE:  if (start) state_nxt = FETCH;
            FETCH: begin
                if (!skip)         state_nxt = WRITE;
                else if (last_pix) state_nxt = DONE;
            end
            WRITE: begin
                if (fb.fb_ack) state_nxt = last_pix ? DONE : FETCH;
            end
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: latch job parameters on start, capture the pixel in FETCH,
    // step the scan counters after each written or skipped pixel.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            org_x  <= '0;
            org_y  <= '0;
            fg_q   <= '0;
            bg_q   <= '0;
            cx     <= '0;
            cy     <= '0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            if (accept) begin
                org_x <= origin_x;
                org_y <= origin_y;
                fg_q  <= fg_color;
                bg_q  <= bg_color;
                cx    <= '0;
                cy    <= '0;
            end
            // Only pixels that will be written load the output registers,
            // keeping fb_addr/fb_data steady across the WRITE wait.
            if (state == FETCH && !skip) begin
                addr_q <= pix_addr;
                data_q <= map_pixel ? fg_q : bg_q;
            end
            if (advance) begin
                if (cx == CX_LAST) begin
                    cx <= '0;
                    cy <= cy + 5'd1;
                end else begin
                    cx <= cx + 6'd1;
                end
            end
        end
    end

    assign map_x      = cx;
    assign map_y      = cy;
    assign fb.fb_we   = (state == WRITE);
    assign fb.fb_addr = addr_q;
    assign fb.fb_data = data_q;
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);

endmodule

// File: tb/tb_text_banner_blitter.sv
// Directed bench for text_banner_blitter: an opaque instance (dut0) with a
// bench-driven ack and a transparent instance (dut1) with ack tied to fb_we.
// The text map stub returns 1 where (x+y) is odd.
module tb_text_banner_blitter;

    localparam int TW      = 24;
    localparam int TH      = 32;
    localparam int MAX_CYC = 8000;
    localparam logic [7:0] FG = 8'hA5;
    localparam logic [7:0] BG = 8'h3C;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       start0, start1;
    logic [9:0] origin_x;
    logic [8:0] origin_y;
    logic [7:0] fg_color, bg_color;
    logic [5:0] map_x0, map_x1;
    logic [4:0] map_y0, map_y1;
    logic       map_pixel0, map_pixel1;
    logic       busy0, busy1, done0, done1;

    text_banner_blitter_if fb0 ();
    text_banner_blitter_if fb1 ();

    always #5 Clk = ~Clk;

    assign map_pixel0 = map_x0[0] ^ map_y0[0];
    assign map_pixel1 = map_x1[0] ^ map_y1[0];
    assign fb1.fb_ack = fb1.fb_we;

    text_banner_blitter #(.TEXT_W(TW), .TEXT_H(TH), .TRANSPARENT(1'b0)) dut0 (
        .Clk       (Clk),
        .Reset     (Reset),
        .start     (start0),
        .origin_x  (origin_x),
        .origin_y  (origin_y),
        .fg_color  (fg_color),
        .bg_color  (bg_color),
        .map_x     (map_x0),
        .map_y     (map_y0),
        .map_pixel (map_pixel0),
        .fb        (fb0),
        .busy      (busy0),
        .done      (done0)
    );

    text_banner_blitter #(.TEXT_W(TW), .TEXT_H(TH), .TRANSPARENT(1'b1)) dut1 (
        .Clk       (Clk),
        .Reset     (Reset),
        .start     (start1),
        .origin_x  (origin_x),
        .origin_y  (origin_y),
        .fg_color  (fg_color),
        .bg_color  (bg_color),
        .map_x     (map_x1),
        .map_y     (map_y1),
        .map_pixel (map_pixel1),
        .fb        (fb1),
        .busy      (busy1),
        .done      (done1)
    );

    int n_vec = 0;
    int n_err = 0;

    // Results of the most recent render
    int r_writes, r_cycles, r_done, r_first_addr, r_first_data, r_last_addr;
    int r_max_addr, r_order_err, r_dup, r_unstable, r_not_fg, r_hit_32100;
    int r_missing, r_timeout;

    // Starts one render and monitors it cycle by cycle at the falling edge.
    // Each write is compared in order against a scan-order model of the
    // banner; ack_period=1 means ack always high, N means every Nth cycle.
    // With spam set, start stays high and origin/colour keep changing until
    // done. abort_at>=0 returns right after that many writes.
    task automatic run_render(input bit sel, input logic [9:0] ox, input logic [8:0] oy,
                              input int ack_period, input bit spam, input int abort_at);
        wr_t        exp_q[$];
        wr_t        e;
        bit         seen[int];
        int         sx, sy, addr, data, prev_addr, prev_data, tail;
        bit         p, we, ack, dn, prev_wait, aborted;
        logic [7:0] fg_l, bg_l;

        fg_l = fg_color;
        bg_l = bg_color;
        for (int y = 0; y < TH; y++) begin
            for (int x = 0; x < TW; x++) begin
                sx = int'(ox) + x;
                sy = int'(oy) + y;
                p  = ((x + y) % 2) == 1;
                if (sx < 640 && sy < 480 && !(sel && !p)) begin
                    e.addr = sy * 640 + sx;
                    e.data = p ? int'(fg_l) : int'(bg_l);
                    exp_q.push_back(e);
                end
            end
        end

        r_writes = 0; r_cycles = 0; r_done = 0; r_first_addr = -1; r_first_data = -1;
        r_last_addr = -1; r_max_addr = -1; r_order_err = 0; r_dup = 0; r_unstable = 0;
        r_not_fg = 0; r_hit_32100 = 0; r_missing = 0; r_timeout = 0;
        prev_wait = 1'b0; prev_addr = 0; prev_data = 0; tail = 0; aborted = 1'b0;

        @(negedge Clk);
        origin_x = ox;
        origin_y = oy;
        if (sel) start1 = 1'b1;
        else     start0 = 1'b1;

        for (int c = 1; c <= MAX_CYC; c++) begin
            @(negedge Clk);
            if (!sel) fb0.fb_ack = (ack_period <= 1) || (c % ack_period == 0);
            we   = sel ? fb1.fb_we : fb0.fb_we;
            addr = int'(sel ? fb1.fb_addr : fb0.fb_addr);
            data = int'(sel ? fb1.fb_data : fb0.fb_data);
            dn   = sel ? done1 : done0;
            ack  = sel ? we : fb0.fb_ack;

            if (prev_wait && (!we || addr != prev_addr || data != prev_data))
                r_unstable++;

            if (we && ack) begin
                if (exp_q.size() == 0) begin
                    r_order_err++;
                end else begin
                    e = exp_q.pop_front();
                    if (e.addr != addr || e.data != data) r_order_err++;
                end
                if (seen.exists(addr)) r_dup++;
                seen[addr] = 1'b1;
                if (r_writes == 0) begin
                    r_first_addr = addr;
                    r_first_data = data;
                end
                r_last_addr = addr;
                if (addr > r_max_addr) r_max_addr = addr;
                if (data != int'(fg_l)) r_not_fg++;
                if (addr == 32100) r_hit_32100++;
                r_writes++;
            end
            prev_wait = we && !ack;
            prev_addr = addr;
            prev_data = data;

            if (dn) begin
                if (r_done == 0) r_cycles = c;
                r_done++;
            end

            if (spam && !sel && r_done == 0) begin
                start0   = 1'b1;
                origin_x = 10'(c * 7);
                origin_y = 9'(c * 3);
                fg_color = 8'(c);
                bg_color = 8'(c + 1);
            end else begin
                start0 = 1'b0;
                start1 = 1'b0;
            end

            if (abort_at >= 0 && r_writes == abort_at) begin
                aborted = 1'b1;
                break;
            end
            if (r_done > 0) begin
                tail++;
                if (tail >= 4) break;
            end
        end

        if (r_done == 0 && !aborted) r_timeout = 1;
        r_missing   = exp_q.size();
        start0      = 1'b0;
        start1      = 1'b0;
        fb0.fb_ack  = 1'b0;
        fg_color    = fg_l;
        bg_color    = bg_l;
    endtask

    task automatic test_reset();
        Reset = 1'b1; start0 = 1'b0; start1 = 1'b0; fb0.fb_ack = 1'b0;
        origin_x = '0; origin_y = '0; fg_color = FG; bg_color = BG;
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        n_vec++;
        if ({busy0, done0, fb0.fb_we, fb0.fb_addr, fb0.fb_data, map_x0, map_y0} !== 41'd0) begin
            n_err++;
            $display("FAIL reset_dut0: got %h expected 0",
                     {busy0, done0, fb0.fb_we, fb0.fb_addr, fb0.fb_data, map_x0, map_y0});
        end
        n_vec++;
        if ({busy1, done1, fb1.fb_we, fb1.fb_addr, fb1.fb_data, map_x1, map_y1} !== 41'd0) begin
            n_err++;
            $display("FAIL reset_dut1: got %h expected 0",
                     {busy1, done1, fb1.fb_we, fb1.fb_addr, fb1.fb_data, map_x1, map_y1});
        end
        // ack while idle is ignored
        fb0.fb_ack = 1'b1;
        repeat (2) @(negedge Clk);
        n_vec++;
        if ({busy0, fb0.fb_we} !== 2'b00) begin
            n_err++;
            $display("FAIL idle_ack: busy/we got %b expected 00", {busy0, fb0.fb_we});
        end
        fb0.fb_ack = 1'b0;
        // start and Reset together: Reset wins
        Reset = 1'b1; start0 = 1'b1;
        @(negedge Clk);
        Reset = 1'b0; start0 = 1'b0;
        n_vec++;
        if (busy0 !== 1'b0) begin
            n_err++;
            $display("FAIL start_with_reset: busy got %b expected 0", busy0);
        end
    endtask

    task automatic test_opaque();
        run_render(1'b0, 10'd100, 9'd50, 1, 1'b0, -1);
        n_vec++;
        if (r_writes !== 768) begin
            n_err++; $display("FAIL opaque_writes: got %0d expected 768", r_writes);
        end
        n_vec++;
        if (r_first_addr !== 32100 || r_first_data !== int'(BG)) begin
            n_err++;
            $display("FAIL opaque_first: got addr %0d data %0d expected addr 32100 data %0d",
                     r_first_addr, r_first_data, BG);
        end
        n_vec++;
        if (r_last_addr !== 51963) begin
            n_err++; $display("FAIL opaque_last_addr: got %0d expected 51963", r_last_addr);
        end
        n_vec++;
        if (r_done !== 1) begin
            n_err++; $display("FAIL opaque_done: got %0d pulses expected 1", r_done);
        end
        n_vec++;
        if (r_cycles < 1536 || r_cycles > 1538) begin
            n_err++; $display("FAIL opaque_cycles: got %0d expected 1537 +-1", r_cycles);
        end
        n_vec++;
        if (r_order_err !== 0 || r_missing !== 0) begin
            n_err++;
            $display("FAIL opaque_sequence: got %0d wrong, %0d missing expected 0, 0",
                     r_order_err, r_missing);
        end
    endtask

    task automatic test_transparent();
        run_render(1'b1, 10'd100, 9'd50, 1, 1'b0, -1);
        n_vec++;
        if (r_writes !== 384) begin
            n_err++; $display("FAIL transp_writes: got %0d expected 384", r_writes);
        end
        n_vec++;
        if (r_not_fg !== 0) begin
            n_err++; $display("FAIL transp_fg_only: got %0d non-fg writes expected 0", r_not_fg);
        end
        n_vec++;
        if (r_hit_32100 !== 0) begin
            n_err++; $display("FAIL transp_skip_32100: got %0d writes expected 0", r_hit_32100);
        end
        n_vec++;
        if (r_done !== 1 || r_order_err !== 0) begin
            n_err++;
            $display("FAIL transp_sequence: got done %0d wrong %0d expected 1, 0",
                     r_done, r_order_err);
        end
    endtask

    task automatic test_backpressure();
        run_render(1'b0, 10'd100, 9'd50, 4, 1'b0, -1);
        n_vec++;
        if (r_unstable !== 0) begin
            n_err++; $display("FAIL bp_stable: got %0d changes while waiting expected 0", r_unstable);
        end
        n_vec++;
        if (r_writes !== 768 || r_dup !== 0 || r_missing !== 0) begin
            n_err++;
            $display("FAIL bp_coverage: got %0d writes %0d dup %0d missing expected 768, 0, 0",
                     r_writes, r_dup, r_missing);
        end
        n_vec++;
        if (r_order_err !== 0 || r_done !== 1) begin
            n_err++;
            $display("FAIL bp_sequence: got wrong %0d done %0d expected 0, 1", r_order_err, r_done);
        end
    endtask

    task automatic test_clip();
        run_render(1'b0, 10'd630, 9'd470, 1, 1'b0, -1);
        n_vec++;
        if (r_writes !== 100) begin
            n_err++; $display("FAIL clip_writes: got %0d expected 100", r_writes);
        end
        n_vec++;
        if (r_max_addr !== 307199) begin
            n_err++; $display("FAIL clip_max_addr: got %0d expected 307199", r_max_addr);
        end
        n_vec++;
        if (r_done !== 1 || r_order_err !== 0) begin
            n_err++;
            $display("FAIL clip_sequence: got done %0d wrong %0d expected 1, 0", r_done, r_order_err);
        end
    endtask

    task automatic test_start_spam();
        run_render(1'b0, 10'd100, 9'd50, 1, 1'b1, -1);
        n_vec++;
        if (r_writes !== 768 || r_done !== 1) begin
            n_err++;
            $display("FAIL spam_single: got %0d writes %0d done expected 768, 1", r_writes, r_done);
        end
        n_vec++;
        if (r_order_err !== 0) begin
            n_err++; $display("FAIL spam_latched: got %0d wrong writes expected 0", r_order_err);
        end
        n_vec++;
        if (busy0 !== 1'b0) begin
            n_err++; $display("FAIL spam_idle_after: busy got %b expected 0", busy0);
        end
    endtask

    task automatic test_reset_mid();
        int dn_cnt;
        run_render(1'b0, 10'd100, 9'd50, 1, 1'b0, 200);
        n_vec++;
        if (r_writes !== 200 || busy0 !== 1'b1 || r_done !== 0) begin
            n_err++;
            $display("FAIL abort_point: got %0d writes busy %b done %0d expected 200, 1, 0",
                     r_writes, busy0, r_done);
        end
        Reset = 1'b1;
        @(negedge Clk);
        n_vec++;
        if ({busy0, done0, fb0.fb_we, fb0.fb_addr, fb0.fb_data, map_x0, map_y0} !== 41'd0) begin
            n_err++;
            $display("FAIL abort_outputs: got %h expected 0",
                     {busy0, done0, fb0.fb_we, fb0.fb_addr, fb0.fb_data, map_x0, map_y0});
        end
        @(negedge Clk);
        Reset = 1'b0;
        dn_cnt = 0;
        repeat (6) begin
            @(negedge Clk);
            if (done0) dn_cnt++;
        end
        n_vec++;
        if (dn_cnt !== 0) begin
            n_err++; $display("FAIL abort_no_done: got %0d pulses expected 0", dn_cnt);
        end
        run_render(1'b0, 10'd0, 9'd0, 1, 1'b0, -1);
        n_vec++;
        if (r_first_addr !== 0 || r_first_data !== int'(BG)) begin
            n_err++;
            $display("FAIL restart_first: got addr %0d data %0d expected addr 0 data %0d",
                     r_first_addr, r_first_data, BG);
        end
        n_vec++;
        if (r_writes !== 768 || r_order_err !== 0 || r_done !== 1) begin
            n_err++;
            $display("FAIL restart_render: got %0d writes %0d wrong %0d done expected 768, 0, 1",
                     r_writes, r_order_err, r_done);
        end
    endtask

    initial begin
        test_reset();
        test_opaque();
        test_transparent();
        test_backpressure();
        test_clip();
        test_start_spam();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
